// File: rtl/bus_pkg.sv
// Shared definitions for the serial system bus: master state encoding,
// default widths and the wire bit order used by master, slave and arbiter.
package bus_pkg;

  localparam int ADDR_W_DEF = 15;
  localparam int DATA_W_DEF = 8;

  // Address and data words travel LSB first on B_BUS_OUT / B_BUS_IN.
  localparam bit BUS_LSB_FIRST = 1'b1;

  typedef enum logic [3:0] {
    MS_IDLE     = 4'd0,
    MS_REQ      = 4'd1,
    MS_ADDR     = 4'd2,
    MS_ADDR_ACK = 4'd3,
    MS_WDATA    = 4'd4,
    MS_WR_ACK   = 4'd5,
    MS_RDATA    = 4'd6,
    MS_SPLIT    = 4'd7,
    MS_DONE     = 4'd8
  } mstate_e;

  // Position inside a word of the k-th bit sent or received on the wire.
  function automatic int bus_bit_pos(input int k, input int width);
    return BUS_LSB_FIRST ? k : width - 1 - k;
  endfunction

endpackage

// File: rtl/counter.sv
// Free-running up counter with synchronous reset and synchronous clear.
module counter #(
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_count
);

  // NOTE: sequential state is updated with <= only, so every flop samples
  // the pre-edge value of every other flop regardless of block ordering.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      o_count <= '0;
    end else if (i_en) begin
      o_count <= o_count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/master_port_serial.sv
// Serial bus master port: takes one parallel request, arbitrates, shifts
// address/write data out, gathers read data, and handles ACK timeout and split.
module master_port_serial
  import bus_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACK_TO = 4,
  parameter int CNT_W  = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              M_REQ,
  input  logic              M_RW,
  input  logic [ADDR_W-1:0] M_ADDR,
  input  logic [DATA_W-1:0] M_WDATA,
  output logic              M_READY,
  output logic              M_DONE,
  output logic              M_ERR,
  output logic [DATA_W-1:0] M_RDATA,
  output logic              B_REQ,
  input  logic              B_GRANT,
  output logic              B_RW,
  output logic              B_VALID,
  output logic              B_BUS_OUT,
  input  logic              B_BUS_IN,
  input  logic              B_ACK,
  input  logic              B_SPLIT,
  input  logic              B_SPL_RESUME
);

  mstate_e           r_state;
  mstate_e           w_state_nxt;
  logic              r_rw;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata_acc;
  logic [DATA_W-1:0] w_rdata_acc_nxt;

  logic              r_m_ready;
  logic              r_m_done;
  logic              r_m_err;
  logic [DATA_W-1:0] r_m_rdata;
  logic              r_b_req;
  logic              r_b_valid;
  logic              r_b_bus_out;

  logic [CNT_W-1:0]  w_bit_cnt;
  logic [CNT_W-1:0]  w_bit_cnt_nxt;
  logic [CNT_W-1:0]  w_to_cnt;
  logic              w_state_chg;
  logic              w_bit_en;
  logic              w_to_en;
  logic              w_abort;
  logic              w_last_addr;
  logic              w_last_data;
  logic              w_to_expired;
  logic              w_split;
  logic              w_addr_bit;
  logic              w_wdata_bit;

  assign w_last_addr  = (w_bit_cnt == CNT_W'(ADDR_W - 1));
  assign w_last_data  = (w_bit_cnt == CNT_W'(DATA_W - 1));
  assign w_to_expired = (w_to_cnt  == CNT_W'(ACK_TO - 1));
  assign w_split      = B_SPLIT && !B_SPL_RESUME;

  // NOTE: every signal assigned in this block gets a default first, so no
  // path through the case statement can leave it unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_abort     = 1'b0;
    case (r_state)
      MS_IDLE, MS_DONE: begin
        if (M_REQ) w_state_nxt = MS_REQ;
        else       w_state_nxt = MS_IDLE;
      end
      MS_REQ: begin
        if (B_GRANT) w_state_nxt = MS_ADDR;
      end
      MS_ADDR: begin
        if (!B_GRANT)         w_abort     = 1'b1;
        else if (w_last_addr) w_state_nxt = MS_ADDR_ACK;
      end
      MS_ADDR_ACK: begin
        if (!B_GRANT)          w_abort     = 1'b1;
        else if (B_ACK)        w_state_nxt = r_rw ? MS_WDATA : MS_RDATA;
        else if (w_to_expired) w_abort     = 1'b1;
      end
      MS_WDATA: begin
        if (!B_GRANT)         w_abort     = 1'b1;
        else if (w_last_data) w_state_nxt = MS_WR_ACK;
      end
      MS_WR_ACK: begin
        if (!B_GRANT)          w_abort     = 1'b1;
        else if (B_ACK)        w_state_nxt = MS_DONE;
        else if (w_to_expired) w_abort     = 1'b1;
      end
      MS_RDATA: begin
        // The arbiter may pull grant together with the split; split takes precedence.
        if (w_split)          w_state_nxt = MS_SPLIT;
        else if (!B_GRANT)    w_abort     = 1'b1;
        else if (w_last_data) w_state_nxt = MS_DONE;
      end
      MS_SPLIT: begin
        if (!B_SPLIT || B_SPL_RESUME) w_state_nxt = MS_RDATA;
      end
      default: w_state_nxt = MS_IDLE;
    endcase
    if (w_abort) w_state_nxt = MS_IDLE;
  end

  // Both counters restart from zero on every state change.
  assign w_state_chg = (w_state_nxt != r_state);
  assign w_bit_en    = (r_state == MS_ADDR) || (r_state == MS_WDATA) ||
                       (r_state == MS_RDATA);
  assign w_to_en     = (r_state == MS_ADDR_ACK) || (r_state == MS_WR_ACK);

  counter #(.WIDTH(CNT_W)) u_bit_cnt (
    .i_clk   (CLK),
    .i_rst   (RST),
    .i_clr   (w_state_chg),
    .i_en    (w_bit_en),
    .o_count (w_bit_cnt)
  );

  counter #(.WIDTH(CNT_W)) u_to_cnt (
    .i_clk   (CLK),
    .i_rst   (RST),
    .i_clr   (w_state_chg),
    .i_en    (w_to_en),
    .o_count (w_to_cnt)
  );

  // Serial outputs are registered, so they are loaded with the bit for the
  // counter value the next cycle will hold.
  assign w_bit_cnt_nxt = w_state_chg ? '0 :
                         (w_bit_en ? w_bit_cnt + CNT_W'(1) : w_bit_cnt);
  assign w_addr_bit  = 1'(r_addr  >> bus_bit_pos(int'(w_bit_cnt_nxt), ADDR_W));
  assign w_wdata_bit = 1'(r_wdata >> bus_bit_pos(int'(w_bit_cnt_nxt), DATA_W));
  assign w_rdata_acc_nxt = r_rdata_acc |
                           (DATA_W'(B_BUS_IN) << bus_bit_pos(int'(w_bit_cnt), DATA_W));

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= MS_IDLE;
      r_rw        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rdata_acc <= '0;
      r_m_ready   <= 1'b1;
      r_m_done    <= 1'b0;
      r_m_err     <= 1'b0;
      r_m_rdata   <= '0;
      r_b_req     <= 1'b0;
      r_b_valid   <= 1'b0;
      r_b_bus_out <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_m_ready && M_REQ) begin
        r_rw    <= M_RW;
        r_addr  <= M_ADDR;
        r_wdata <= M_WDATA;
      end
      // A split discards the partial byte; RDATA re-entry starts from bit 0.
      if (r_state == MS_RDATA && w_state_nxt == MS_RDATA) r_rdata_acc <= w_rdata_acc_nxt;
      else                                                 r_rdata_acc <= '0;
      if (r_state == MS_RDATA && w_state_nxt == MS_DONE) r_m_rdata <= w_rdata_acc_nxt;

      r_m_ready   <= (w_state_nxt == MS_IDLE) || (w_state_nxt == MS_DONE);
      r_m_done    <= (w_state_nxt == MS_DONE);
      r_m_err     <= w_abort;
      r_b_req     <= (w_state_nxt != MS_IDLE) && (w_state_nxt != MS_DONE);
      r_b_valid   <= (w_state_nxt == MS_ADDR) || (w_state_nxt == MS_WDATA);
      r_b_bus_out <= (w_state_nxt == MS_ADDR)  ? w_addr_bit  :
                     (w_state_nxt == MS_WDATA) ? w_wdata_bit : 1'b0;
    end
  end

  assign M_READY   = r_m_ready;
  assign M_DONE    = r_m_done;
  assign M_ERR     = r_m_err;
  assign M_RDATA   = r_m_rdata;
  assign B_REQ     = r_b_req;
  assign B_RW      = r_rw;
  assign B_VALID   = r_b_valid;
  assign B_BUS_OUT = r_b_bus_out;

endmodule

// File: tb/tb_master_port_serial.sv
// Directed bench for master_port_serial: write, read, ACK timeout, split,
// grant loss and mid-transaction reset, checked with immediate assertions.
module tb_master_port_serial;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        M_REQ = 1'b0;
  logic        M_RW = 1'b0;
  logic [14:0] M_ADDR = '0;
  logic [7:0]  M_WDATA = '0;
  logic        M_READY;
  logic        M_DONE;
  logic        M_ERR;
  logic [7:0]  M_RDATA;
  logic        B_REQ;
  logic        B_GRANT = 1'b0;
  logic        B_RW;
  logic        B_VALID;
  logic        B_BUS_OUT;
  logic        B_BUS_IN = 1'b0;
  logic        B_ACK = 1'b0;
  logic        B_SPLIT = 1'b0;
  logic        B_SPL_RESUME = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  master_port_serial dut (
    .CLK          (CLK),
    .RST          (RST),
    .M_REQ        (M_REQ),
    .M_RW         (M_RW),
    .M_ADDR       (M_ADDR),
    .M_WDATA      (M_WDATA),
    .M_READY      (M_READY),
    .M_DONE       (M_DONE),
    .M_ERR        (M_ERR),
    .M_RDATA      (M_RDATA),
    .B_REQ        (B_REQ),
    .B_GRANT      (B_GRANT),
    .B_RW         (B_RW),
    .B_VALID      (B_VALID),
    .B_BUS_OUT    (B_BUS_OUT),
    .B_BUS_IN     (B_BUS_IN),
    .B_ACK        (B_ACK),
    .B_SPLIT      (B_SPLIT),
    .B_SPL_RESUME (B_SPL_RESUME)
  );

  // Outputs are observed and inputs changed 1 time unit after each rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present a request in IDLE; returns in the first REQ cycle.
  task automatic accept(input logic rw, input logic [14:0] addr, input logic [7:0] wdata);
    M_REQ   = 1'b1;
    M_RW    = rw;
    M_ADDR  = addr;
    M_WDATA = wdata;
    tick();
    M_REQ   = 1'b0;
  endtask

  // Record n serial bits driven by the master, LSB first.
  task automatic shift_out(input int n, output logic [31:0] bits, output logic valid_ok);
    bits     = '0;
    valid_ok = 1'b1;
    for (int k = 0; k < n; k++) begin
      bits[k] = B_BUS_OUT;
      if (B_VALID !== 1'b1) valid_ok = 1'b0;
      tick();
    end
  endtask

  // Slave side: return a byte LSB first, watching B_VALID and B_REQ.
  task automatic shift_in(input logic [7:0] v, output logic quiet_ok);
    quiet_ok = 1'b1;
    for (int k = 0; k < 8; k++) begin
      B_BUS_IN = v[k];
      if (B_VALID !== 1'b0 || B_REQ !== 1'b1) quiet_ok = 1'b0;
      tick();
    end
    B_BUS_IN = 1'b0;
  endtask

  initial begin
    logic [31:0] bits;
    logic        vok;
    logic        ok;

    // ---------------- reset ----------------
    tick();
    tick();
    check("rst_ready", 32'(M_READY), 1);
    check("rst_ctrl", 32'({M_DONE, M_ERR, B_REQ, B_RW, B_VALID, B_BUS_OUT}), 0);
    check("rst_rdata", 32'(M_RDATA), 0);
    RST = 1'b0;
    tick();

    // ---------------- write 0xA5 to 0x0A46 ----------------
    accept(1'b1, 15'h0A46, 8'hA5);
    check("wr_req_ready", 32'(M_READY), 0);
    check("wr_req_breq", 32'({B_REQ, B_RW}), 32'h3);
    tick();
    tick();
    check("wr_wait_grant_valid", 32'(B_VALID), 0);
    B_GRANT = 1'b1;
    tick();
    shift_out(15, bits, vok);
    check("wr_addr_bits", bits, 32'h0A46);
    check("wr_addr_valid", 32'(vok), 1);
    check("wr_addr_ack_idle", 32'({B_VALID, B_BUS_OUT}), 0);
    B_ACK = 1'b1;
    tick();
    B_ACK = 1'b0;
    shift_out(8, bits, vok);
    check("wr_data_bits", bits, 32'hA5);
    check("wr_data_valid", 32'(vok), 1);
    check("wr_ack_wait_valid", 32'(B_VALID), 0);
    B_ACK = 1'b1;
    tick();
    B_ACK = 1'b0;
    B_GRANT = 1'b0;
    check("wr_done", 32'({M_DONE, M_ERR, B_REQ, M_READY}), 32'b1001);
    check("wr_rdata_kept", 32'(M_RDATA), 0);
    tick();
    check("wr_after_done", 32'({M_DONE, M_ERR, M_READY}), 32'b001);

    // ---------------- read 0xBF from 0x0004; M_REQ held high is ignored ----------------
    accept(1'b0, 15'h0004, 8'h00);
    M_REQ  = 1'b1;
    M_ADDR = 15'h7FFF;
    check("rd_req_rw", 32'({B_REQ, B_RW}), 32'h2);
    B_GRANT = 1'b1;
    tick();
    shift_out(15, bits, vok);
    M_REQ = 1'b0;
    check("rd_addr_bits", bits, 32'h0004);
    B_ACK = 1'b1;
    tick();
    B_ACK = 1'b0;
    shift_in(8'hBF, ok);
    check("rd_bus_quiet", 32'(ok), 1);
    B_GRANT = 1'b0;
    check("rd_done", 32'({M_DONE, M_ERR, B_REQ, M_READY}), 32'b1001);
    check("rd_rdata", 32'(M_RDATA), 32'hBF);
    tick();
    check("rd_rdata_hold", 32'({M_DONE, M_RDATA}), 32'h0BF);

    // ---------------- ACK timeout after address ----------------
    accept(1'b0, 15'h1234, 8'h00);
    B_GRANT = 1'b1;
    tick();
    shift_out(15, bits, vok);
    tick();
    tick();
    tick();
    check("to_cycle4_no_err", 32'({M_ERR, B_REQ}), 32'b01);
    tick();
    check("to_err_pulse", 32'({M_ERR, M_DONE, B_REQ, M_READY}), 32'b1001);
    B_GRANT = 1'b0;
    tick();
    check("to_err_clear", 32'({M_ERR, M_DONE}), 0);

    // ---------------- split after 3 read bits, resend 0x3C ----------------
    accept(1'b0, 15'h0100, 8'h00);
    B_GRANT = 1'b1;
    tick();
    shift_out(15, bits, vok);
    B_ACK = 1'b1;
    tick();
    B_ACK = 1'b0;
    ok = 1'b1;
    for (int k = 0; k < 3; k++) begin
      B_BUS_IN = 1'b1;
      tick();
    end
    B_BUS_IN = 1'b1;
    B_SPLIT  = 1'b1;
    tick();
    B_BUS_IN = 1'b0;
    B_GRANT  = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (B_REQ !== 1'b1 || B_VALID !== 1'b0 || M_ERR !== 1'b0 || M_DONE !== 1'b0) ok = 1'b0;
      tick();
    end
    check("spl_hold", 32'(ok), 1);
    B_SPL_RESUME = 1'b1;
    B_GRANT      = 1'b1;
    tick();
    B_SPL_RESUME = 1'b0;
    B_SPLIT      = 1'b0;
    shift_in(8'h3C, ok);
    check("spl_resend_quiet", 32'(ok), 1);
    B_GRANT = 1'b0;
    check("spl_done", 32'({M_DONE, M_ERR}), 32'b10);
    check("spl_rdata", 32'(M_RDATA), 32'h3C);
    tick();

    // ---------------- grant loss in address bit 7 ----------------
    accept(1'b1, 15'h2AAA, 8'h11);
    B_GRANT = 1'b1;
    tick();
    shift_out(7, bits, vok);
    check("gl_addr_low7", bits, 32'h2A);
    check("gl_bit7", 32'({B_VALID, B_BUS_OUT}), 32'b11);
    B_GRANT = 1'b0;
    tick();
    check("gl_err", 32'({M_ERR, M_DONE, B_VALID, B_REQ, M_READY}), 32'b10001);
    tick();
    check("gl_after", 32'({M_ERR, M_DONE}), 0);

    // ---------------- reset at write data bit 4 ----------------
    accept(1'b1, 15'h0A46, 8'h5A);
    B_GRANT = 1'b1;
    tick();
    shift_out(15, bits, vok);
    B_ACK = 1'b1;
    tick();
    B_ACK = 1'b0;
    shift_out(4, bits, vok);
    check("rst_mid_pre_valid", 32'(B_VALID), 1);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    B_GRANT = 1'b0;
    check("rst_mid_ctrl", 32'({M_READY, M_DONE, M_ERR, B_REQ, B_RW, B_VALID, B_BUS_OUT}), 32'h40);
    check("rst_mid_rdata", 32'(M_RDATA), 0);
    tick();
    check("rst_mid_no_pulse", 32'({M_DONE, M_ERR}), 0);

    // New write completes; data ACK arrives on the last timeout cycle and wins.
    accept(1'b1, 15'h0123, 8'h5A);
    B_GRANT = 1'b1;
    tick();
    shift_out(15, bits, vok);
    check("post_addr_bits", bits, 32'h0123);
    B_ACK = 1'b1;
    tick();
    B_ACK = 1'b0;
    shift_out(8, bits, vok);
    check("post_data_bits", bits, 32'h5A);
    tick();
    tick();
    tick();
    check("post_ack_late_wait", 32'({M_ERR, B_REQ}), 32'b01);
    B_ACK = 1'b1;
    tick();
    B_ACK = 1'b0;
    B_GRANT = 1'b0;
    check("post_ack_wins", 32'({M_DONE, M_ERR, B_REQ, M_READY}), 32'b1001);
    tick();
    check("post_idle", 32'({M_DONE, M_ERR, M_READY}), 32'b001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/master_port_serial.md
Name: master_port_serial

Overview:
Bus-master port on the serial system bus, directly upstream of the 4K split-capable slave. Accepts one parallel read/write request from a local user and requests the bus from the arbiter. Shifts the address and write data out bit-serially, collects serial read data, and handles ACK, timeout and split/resume. Returns the read byte, or a done/error pulse, to the user.

Parameters:
ADDR_W, 15, serial address width (upper bits = slave select, [12:1] = 4K word address)
DATA_W, 8, data byte width
ACK_TO, 4, max cycles to wait for B_ACK before abort
CNT_W, 4, bit-counter width (must hold max(ADDR_W, DATA_W))

Ports:
CLK  in  1  system clock
RST  in  1  synchronous active-high reset
M_REQ  in  1  user request; sampled only when M_READY=1
M_RW  in  1  1=write, 0=read
M_ADDR  in  ADDR_W  target address
M_WDATA  in  DATA_W  write byte
M_READY  out  1  port idle, can accept request
M_DONE  out  1  one-cycle pulse: transaction completed
M_ERR  out  1  one-cycle pulse: transaction aborted
M_RDATA  out  DATA_W  read byte; valid from M_DONE until next request accepted
B_REQ  out  1  bus request to arbiter
B_GRANT  in  1  bus grant from arbiter
B_RW  out  1  transfer direction to slave
B_VALID  out  1  high while master drives a serial bit on B_BUS_OUT
B_BUS_OUT  out  1  serial address/write data, LSB first
B_BUS_IN  in  1  serial read data from slave, LSB first
B_ACK  in  1  slave acknowledge
B_SPLIT  in  1  arbiter: current transaction split
B_SPL_RESUME  in  1  arbiter: split slave resuming

Behaviour:
- All outputs are registered. RST is synchronous, active-high, and the only reset.
- Reset values: M_READY=1, M_DONE=0, M_ERR=0, M_RDATA=0, B_REQ=0, B_RW=0, B_VALID=0, B_BUS_OUT=0, state=IDLE, counters=0.
- RST asserted mid-transaction returns every output to its reset value at the next edge. No done/err pulse is issued.
- States: IDLE, REQ, ADDR, ADDR_ACK, WDATA, WR_ACK, RDATA, SPLIT, DONE.
- IDLE: on M_REQ, latch M_ADDR/M_WDATA/M_RW and go to REQ. Next cycle M_READY=0, B_REQ=1, B_RW=latched RW.
- REQ: wait indefinitely for B_GRANT. On grant go to ADDR, bit counter cleared.
- ADDR: cycle k (k=0..ADDR_W-1) drives B_BUS_OUT=addr[k] and B_VALID=1. After ADDR_W cycles, go to ADDR_ACK with B_VALID=0 and B_BUS_OUT=0.
- ADDR_ACK: wait up to ACK_TO cycles for B_ACK. On ACK go to WDATA (RW=1) or RDATA (RW=0). On timeout, pulse M_ERR, B_REQ=0, return to IDLE.
- WDATA: DATA_W cycles, B_BUS_OUT=wdata[k], B_VALID=1. Then go to WR_ACK.
- WR_ACK: same timeout rule as ADDR_ACK. On ACK go to DONE.
- RDATA: sample B_BUS_IN into rdata[k] on each of DATA_W cycles. After bit DATA_W-1, go to DONE.
- RDATA split: if B_SPLIT=1 and B_SPL_RESUME=0, go to SPLIT. The partial byte is discarded and the bit counter cleared.
- SPLIT: B_REQ stays 1 and B_VALID=0. No timeout. When B_SPLIT=0 or B_SPL_RESUME=1, re-enter RDATA from bit 0.
- DONE: one cycle. Pulse M_DONE; M_RDATA=assembled byte (reads only, unchanged on writes). B_REQ=0, M_READY=1, then IDLE.
- Grant loss: B_GRANT=0 in ADDR, ADDR_ACK, WDATA, WR_ACK or RDATA aborts the transaction. Pulse M_ERR, B_REQ=0, go to IDLE. B_GRANT is ignored in SPLIT.
- Simultaneous B_ACK and timeout expiry in the same cycle: ACK wins.
- M_REQ while M_READY=0 is ignored (no queueing).
- M_DONE and M_ERR never assert together.

Decomposition:
- Package bus_pkg holds:
  - master state enum
  - ADDR_W/DATA_W defaults
  - the bus bit-order constant (LSB first)
- The slave and arbiter also import bus_pkg.
- Reuse the existing counter module (counter #(.WIDTH(CNT_W))) for the bit counter.
- A second counter instance serves as the ACK timeout counter. No other sub-module.

Test Plan:
- Write: M_ADDR=0x0A46, M_WDATA=0xA5, RW=1, grant after 2 cycles, ACK 1 cycle after address and after data -> B_BUS_OUT shows 15 addr bits then 8 data bits LSB-first, then M_DONE pulse, M_ERR=0, B_REQ drops.
- Read: ADDR=0x0004; slave returns 0xBF LSB-first after ACK -> M_DONE pulse with M_RDATA=0xBF.
- ACK timeout: no B_ACK for ACK_TO=4 cycles after address -> M_ERR pulse on the 5th cycle, B_REQ=0, M_READY=1.
- Split: assert B_SPLIT after 3 read bits, hold 10 cycles, then B_SPL_RESUME; slave resends 0x3C from bit 0 -> M_RDATA=0x3C and B_REQ held high throughout.
- Grant loss: drop B_GRANT in address bit 7 -> M_ERR pulse, B_VALID=0 next cycle, no M_DONE.
- Reset mid-write (RST at data bit 4) -> all outputs at reset values after one edge; new request then completes normally.
